// File: rtl/wave_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory channel, redirect input and decode handshake.
// With WAVE_FETCH_MISALIGN_CHECK_EN defined it also carries the misaligned-target status.
interface wave_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] fetch_pc;
`ifdef WAVE_FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
  logic [31:0] fetch_misaligned_pc;
`endif

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr_data, instr_pc, fetch_pc,
`ifdef WAVE_FETCH_MISALIGN_CHECK_EN
    output fetch_misaligned, fetch_misaligned_pc,
`endif
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr_data, instr_pc, fetch_pc,
`ifdef WAVE_FETCH_MISALIGN_CHECK_EN
    input  fetch_misaligned, fetch_misaligned_pc,
`endif
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    output instr_ready
  );
endinterface

// File: rtl/wave_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one word fetch in flight and buffers {pc, word}
// pairs for decode. Define WAVE_FETCH_MISALIGN_CHECK_EN to trap redirects to misaligned targets.
module wave_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  wave_fetch_unit_if.master bus
);

  localparam int unsigned   PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StReq  = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fetchPc_q, fetchPc_d;
  logic [31:0]     pendPc_q, pendPc_d;
  logic [PtrW:0]   count_q, count_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]     dataMem_q [FIFO_DEPTH];
  logic [31:0]     pcMem_q   [FIFO_DEPTH];

  logic        fifoValid, reqValid, handshake, push, pop;
  logic        outstandingAfter, redirHalt, dropToHalt;
  logic [31:0] redirTarget;

  assign redirTarget = {bus.redirect_pc[31:2], 2'b00};

`ifdef WAVE_FETCH_MISALIGN_CHECK_EN
  logic        misFlag_q, misFlag_d;
  logic [31:0] misPc_q, misPc_d;

  assign redirHalt  = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign dropToHalt = misFlag_q;
  assign bus.fetch_misaligned    = misFlag_q;
  assign bus.fetch_misaligned_pc = misPc_q;

  always_comb begin
    misFlag_d = misFlag_q;
    misPc_d   = misPc_q;
    if (bus.redirect_valid) begin
      misFlag_d = redirHalt;
      if (redirHalt) misPc_d = bus.redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misFlag_q <= 1'b0;
      misPc_q   <= '0;
    end else begin
      misFlag_q <= misFlag_d;
      misPc_q   <= misPc_d;
    end
  end
`else
  logic unusedLowBits;

  assign unusedLowBits = ^bus.redirect_pc[1:0];
  assign redirHalt     = 1'b0;
  assign dropToHalt    = 1'b0;
`endif

  assign fifoValid = rst_n && (count_q != '0);
  assign reqValid  = rst_n && (state_q == StReq) && (count_q < DepthCnt);
  assign handshake = reqValid && bus.imem_req_ready;
  assign pop       = fifoValid && bus.instr_ready;
  assign push      = (state_q == StWait) && bus.imem_resp_valid && !bus.redirect_valid;

  // A response is still owed after this edge if one was just accepted or one is pending and not yet back.
  assign outstandingAfter = ((state_q == StReq) && handshake) ||
                            (((state_q == StWait) || (state_q == StDrop)) && !bus.imem_resp_valid);

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_addr      = fetchPc_q;
  assign bus.fetch_pc       = fetchPc_q;
  assign bus.instr_valid    = fifoValid;
  assign bus.instr_data     = fifoValid ? dataMem_q[rdPtr_q] : '0;
  assign bus.instr_pc       = fifoValid ? pcMem_q[rdPtr_q]   : '0;

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    pendPc_d  = pendPc_q;
    case (state_q)
      StReq: begin
        if (handshake) begin
          pendPc_d  = fetchPc_q;
          fetchPc_d = fetchPc_q + 32'd4;
          state_d   = StWait;
        end
      end
      StWait:  if (bus.imem_resp_valid) state_d = StReq;
      StDrop:  if (bus.imem_resp_valid) state_d = dropToHalt ? StHalt : StReq;
      StHalt:  state_d = StHalt;
      default: state_d = StReq;
    endcase
    if (bus.redirect_valid) begin
      fetchPc_d = redirTarget;
      if (outstandingAfter) state_d = StDrop;
      else                  state_d = redirHalt ? StHalt : StReq;
    end
  end

  always_comb begin
    count_d = count_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (bus.redirect_valid) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PtrW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StReq;
      fetchPc_q <= RESET_PC;
      pendPc_q  <= '0;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      pendPc_q  <= pendPc_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      dataMem_q[wrPtr_q] <= bus.imem_resp_data;
      pcMem_q[wrPtr_q]   <= pendPc_q;
    end
  end

endmodule

// File: tb/tb_wave_fetch_unit.sv
// Self-checking bench for wave_fetch_unit: memory model with programmable latency, a queue of
// expected {pc, word} pops per redirect/reset, redirect vector table plus hand-written corner cases.
module tb_wave_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  wave_fetch_unit_if fetchBus();

  wave_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (fetchBus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    int          latency;
    logic [31:0] expFirst;
    int          words;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] expQ [$];
  int          errors = 0;
  int          checks = 0;
  int          memLatency = 1;
  bit          readyEn = 1'b1;
  bit          resetReq = 1'b1;
  bit          redirectArm = 1'b0;
  logic [31:0] armTarget = '0;
  logic [31:0] armFirst = '0;
  int          armWords = 0;
  bit          memPend;
  int          memWait;
  logic [31:0] memAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory: answers each accepted request memLatency cycles later, shares the reset.
  always @(posedge clk) begin
    fetchBus.imem_resp_valid <= 1'b0;
    if (!rst_n) begin
      memPend <= 1'b0;
      memWait <= 0;
    end else begin
      if (memPend) begin
        if (memWait == 0) begin
          fetchBus.imem_resp_valid <= 1'b1;
          fetchBus.imem_resp_data  <= memWord(memAddr);
          memPend                  <= 1'b0;
        end else begin
          memWait <= memWait - 1;
        end
      end
      if (fetchBus.imem_req_valid && fetchBus.imem_req_ready) begin
        if (memLatency <= 1) begin
          fetchBus.imem_resp_valid <= 1'b1;
          fetchBus.imem_resp_data  <= memWord(fetchBus.imem_addr);
        end else begin
          memPend <= 1'b1;
          memWait <= memLatency - 2;
          memAddr <= fetchBus.imem_addr;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then score any pop the next rising edge will take.
  task automatic applyStimulus();
    @(negedge clk);
    rst_n = !resetReq;
    fetchBus.redirect_valid = redirectArm;
    if (redirectArm) fetchBus.redirect_pc = armTarget;
    redirectArm = 1'b0;
    fetchBus.instr_ready = readyEn && (expQ.size() != 0);
    #1;
    if (fetchBus.instr_valid && fetchBus.instr_ready && (expQ.size() != 0)) begin
      logic [31:0] e;
      e = expQ.pop_front();
      checkOutput("instrPc", fetchBus.instr_pc, e);
      checkOutput("instrData", fetchBus.instr_data, memWord(e));
    end
    if (fetchBus.redirect_valid) begin
      expQ.delete();
      for (int i = 0; i < armWords; i++) expQ.push_back(armFirst + 32'(4 * i));
    end
  endtask

  task automatic armRedirect(input logic [31:0] target, input logic [31:0] first, input int words);
    redirectArm = 1'b1;
    armTarget   = target;
    armFirst    = first;
    armWords    = words;
  endtask

  task automatic waitReq(input logic [31:0] expAddr, input string name);
    int n;
    n = 1;
    applyStimulus();
    while (!(fetchBus.imem_req_valid && fetchBus.imem_req_ready) && n < 40) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "Seen"}, 32'(fetchBus.imem_req_valid), 32'd1);
    checkOutput(name, fetchBus.imem_addr, expAddr);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drainLeft", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset(input int words);
    resetReq = 1'b1;
    expQ.delete();
    repeat (3) applyStimulus();
    checkOutput("rstReqValid", 32'(fetchBus.imem_req_valid), 32'd0);
    checkOutput("rstInstrValid", 32'(fetchBus.instr_valid), 32'd0);
    checkOutput("rstInstrData", fetchBus.instr_data, 32'd0);
    checkOutput("rstInstrPc", fetchBus.instr_pc, 32'd0);
    checkOutput("rstFetchPc", fetchBus.fetch_pc, 32'h0000_0000);
`ifdef WAVE_FETCH_MISALIGN_CHECK_EN
    checkOutput("rstMisFlag", 32'(fetchBus.fetch_misaligned), 32'd0);
    checkOutput("rstMisPc", fetchBus.fetch_misaligned_pc, 32'd0);
`endif
    for (int i = 0; i < words; i++) expQ.push_back(32'(4 * i));
    resetReq = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n                   = 1'b0;
    fetchBus.imem_req_ready = 1'b1;
    fetchBus.redirect_valid = 1'b0;
    fetchBus.redirect_pc    = '0;
    fetchBus.instr_ready    = 1'b0;

    vecs[0] = '{target: 32'hFFFF_FFFC, latency: 1, expFirst: 32'hFFFF_FFFC, words: 3};
    vecs[1] = '{target: 32'h0000_1000, latency: 2, expFirst: 32'h0000_1000, words: 4};
    vecs[2] = '{target: 32'h8000_0000, latency: 4, expFirst: 32'h8000_0000, words: 3};
    vecs[3] = '{target: 32'hFFFF_FFF0, latency: 3, expFirst: 32'hFFFF_FFF0, words: 6};
    vecs[4] = '{target: 32'h0000_0040, latency: 1, expFirst: 32'h0000_0040, words: 2};

    // Streaming after reset release, first-word latency.
    memLatency = 1;
    readyEn    = 1'b1;
    doReset(3);
    applyStimulus();
    checkOutput("firstReqValid", 32'(fetchBus.imem_req_valid), 32'd1);
    checkOutput("firstReqAddr", fetchBus.imem_addr, 32'h0);
    applyStimulus();
    checkOutput("validTooEarly", 32'(fetchBus.instr_valid), 32'd0);
    checkOutput("waitNoReq", 32'(fetchBus.imem_req_valid), 32'd0);
    applyStimulus();
    checkOutput("firstValid", 32'(fetchBus.instr_valid), 32'd1);
    checkOutput("secondReqAddr", fetchBus.imem_addr, 32'h4);
    waitDrain(40);

    // Backpressure: buffer fills, requests stop, then resume at 0x8.
    readyEn = 1'b0;
    doReset(4);
    repeat (8) applyStimulus();
    checkOutput("fullReqValid", 32'(fetchBus.imem_req_valid), 32'd0);
    checkOutput("fullInstrValid", 32'(fetchBus.instr_valid), 32'd1);
    checkOutput("fullHeadPc", fetchBus.instr_pc, 32'h0);
    checkOutput("fullHeadData", fetchBus.instr_data, memWord(32'h0));
    checkOutput("fullFetchPc", fetchBus.fetch_pc, 32'h8);
    readyEn = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("resumeReqValid", 32'(fetchBus.imem_req_valid), 32'd1);
    checkOutput("resumeReqAddr", fetchBus.imem_addr, 32'h8);
    waitDrain(60);

    // Redirect while waiting on the 0x4 response: that response must be dropped.
    memLatency = 3;
    doReset(1);
    waitReq(32'h0, "reqZero");
    waitReq(32'h4, "reqFour");
    armRedirect(32'h100, 32'h100, 3);
    applyStimulus();
    checkOutput("waitRedirNoReq", 32'(fetchBus.imem_req_valid), 32'd0);
    applyStimulus();
    checkOutput("dropInstrValid", 32'(fetchBus.instr_valid), 32'd0);
    waitReq(32'h100, "redirReq100");
    waitDrain(60);

    // Redirect in the same cycle as a response and a pop.
    memLatency = 1;
    readyEn    = 1'b0;
    doReset(1);
    waitReq(32'h0, "reqZeroB");
    waitReq(32'h4, "reqFourB");
    readyEn = 1'b1;
    armRedirect(32'h200, 32'h200, 2);
    applyStimulus();
    checkOutput("popOnRedir", 32'(fetchBus.instr_valid), 32'd1);
    applyStimulus();
    checkOutput("flushValid", 32'(fetchBus.instr_valid), 32'd0);
    checkOutput("flushReqValid", 32'(fetchBus.imem_req_valid), 32'd1);
    checkOutput("flushReqAddr", fetchBus.imem_addr, 32'h200);
    waitDrain(40);

    // Redirect table, including wrap-around targets.
    for (int v = 0; v < 5; v++) begin
      memLatency = vecs[v].latency;
      readyEn    = 1'b1;
      armRedirect(vecs[v].target, vecs[v].expFirst, vecs[v].words);
      applyStimulus();
      waitReq(vecs[v].expFirst, $sformatf("vec%0dFirstReq", v));
      waitDrain(80);
    end

`ifndef WAVE_FETCH_MISALIGN_CHECK_EN
    armRedirect(32'h303, 32'h300, 2);
    applyStimulus();
    waitReq(32'h300, "lowBitsForced");
    waitDrain(40);
`else
    armRedirect(32'h102, 32'h0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("misFlagSet", 32'(fetchBus.fetch_misaligned), 32'd1);
    checkOutput("misPc", fetchBus.fetch_misaligned_pc, 32'h102);
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      checkOutput($sformatf("haltNoReq%0d", c), 32'(fetchBus.imem_req_valid), 32'd0);
    end
    checkOutput("haltInstrValid", 32'(fetchBus.instr_valid), 32'd0);
    armRedirect(32'h200, 32'h200, 2);
    applyStimulus();
    applyStimulus();
    checkOutput("misFlagClear", 32'(fetchBus.fetch_misaligned), 32'd0);
    checkOutput("haltExitReqValid", 32'(fetchBus.imem_req_valid), 32'd1);
    checkOutput("haltExitReqAddr", fetchBus.imem_addr, 32'h200);
    waitDrain(40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
